// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM states,
// byte-enable patterns and small decode helpers.
package memory_access_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size carried in funct3[1:0]
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  // Byte-enable patterns
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // An access is dropped when its size code is reserved (011/111) or the
  // address is not naturally aligned for the access size.
  function automatic logic access_dropped(input logic [2:0] funct3,
                                          input logic [1:0] byte_off);
    logic dropped;
    case (funct3[1:0])
      SIZE_B:  dropped = 1'b0;
      SIZE_H:  dropped = byte_off[0];
      SIZE_W:  dropped = (byte_off != 2'b00);
      default: dropped = 1'b1;
    endcase
    return dropped;
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the
// full read word and sign- or zero-extends it according to funct3.
module memory_access_load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the lane, then extend it to 32 bits.
  always_comb begin
    byte_sel = rdata[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the RV32IM pipeline. Issues data-memory requests for loads
// and stores, aligns store data and byte enables, extracts load data and
// passes non-memory results straight to the MEM/WB register. mem_stall
// holds the upstream stages while an access is outstanding.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_mem_valid,
  input  logic [31:0]           ex_mem_alu_result,
  input  logic [31:0]           ex_mem_rs2_data,
  input  logic                  ex_mem_mem_read,
  input  logic                  ex_mem_mem_write,
  input  logic [2:0]            ex_mem_funct3,
  input  logic [4:0]            ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic                  mem_stall,
  output logic                  mem_wb_valid,
  output logic [31:0]           mem_wb_result,
  output logic [4:0]            mem_wb_rd,
  output logic                  mem_wb_reg_write,
  output logic                  misaligned,
  output logic                  bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  // Request fields, held stable for the whole WAIT period
  logic                  dmem_req_reg,   dmem_req_next;
  logic                  dmem_we_reg,    dmem_we_next;
  logic [ADDR_WIDTH-1:0] dmem_addr_reg,  dmem_addr_next;
  logic [3:0]            dmem_be_reg,    dmem_be_next;
  logic [31:0]           dmem_wdata_reg, dmem_wdata_next;

  // Bookkeeping for the outstanding access
  logic [2:0] funct3_reg,    funct3_next;
  logic [1:0] byte_off_reg,  byte_off_next;
  logic [4:0] rd_reg,        rd_next;
  logic       reg_write_reg, reg_write_next;

  // MEM/WB register and event pulses
  logic        wb_valid_reg,     wb_valid_next;
  logic [31:0] wb_result_reg,    wb_result_next;
  logic [4:0]  wb_rd_reg,        wb_rd_next;
  logic        wb_reg_write_reg, wb_reg_write_next;
  logic        misaligned_reg,   misaligned_next;
  logic        bus_error_reg,    bus_error_next;

  logic        stall_raw;
  logic        is_mem_op;
  logic        drop_op;
  logic [1:0]  in_off;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_result;

  memory_access_load_align u_load_align (
    .rdata    (dmem_rdata),
    .byte_off (byte_off_reg),
    .funct3   (funct3_reg),
    .result   (load_result)
  );

  // Decode the incoming op: lane enables and replicated store data.
  always_comb begin
    in_off    = ex_mem_alu_result[1:0];
    is_mem_op = ex_mem_mem_read | ex_mem_mem_write;
    drop_op   = access_dropped(ex_mem_funct3, in_off);
    case (ex_mem_funct3[1:0])
      SIZE_B: begin
        be_calc    = BE_BYTE0 << in_off;
        wdata_calc = {4{ex_mem_rs2_data[7:0]}};
      end
      SIZE_H: begin
        be_calc    = in_off[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_calc = {2{ex_mem_rs2_data[15:0]}};
      end
      default: begin
        be_calc    = BE_WORD;
        wdata_calc = ex_mem_rs2_data;
      end
    endcase
  end

  // Next-state logic: accept ops in IDLE, wait for ready or timeout in WAIT.
  always_comb begin
    state_next        = state_reg;
    tmo_cnt_next      = tmo_cnt_reg;
    dmem_we_next      = dmem_we_reg;
    dmem_addr_next    = dmem_addr_reg;
    dmem_be_next      = dmem_be_reg;
    dmem_wdata_next   = dmem_wdata_reg;
    funct3_next       = funct3_reg;
    byte_off_next     = byte_off_reg;
    rd_next           = rd_reg;
    reg_write_next    = reg_write_reg;
    wb_valid_next     = 1'b0;
    wb_result_next    = 32'd0;
    wb_rd_next        = 5'd0;
    wb_reg_write_next = 1'b0;
    misaligned_next   = 1'b0;
    bus_error_next    = 1'b0;
    stall_raw         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        tmo_cnt_next = '0;
        if (ex_mem_valid) begin
          if (!is_mem_op) begin
            wb_valid_next     = 1'b1;
            wb_result_next    = ex_mem_alu_result;
            wb_rd_next        = ex_mem_rd;
            wb_reg_write_next = ex_mem_reg_write;
          end else if (drop_op) begin
            misaligned_next = 1'b1;
          end else begin
            // A set mem_read wins, so read+write behaves as a load.
            state_next      = S_WAIT;
            stall_raw       = 1'b1;
            dmem_we_next    = ~ex_mem_mem_read;
            dmem_addr_next  = {ex_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
            dmem_be_next    = be_calc;
            dmem_wdata_next = wdata_calc;
            funct3_next     = ex_mem_funct3;
            byte_off_next   = in_off;
            rd_next         = ex_mem_rd;
            reg_write_next  = ex_mem_reg_write;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_next        = S_IDLE;
          tmo_cnt_next      = '0;
          wb_valid_next     = 1'b1;
          wb_result_next    = dmem_we_reg ? 32'd0 : load_result;
          wb_rd_next        = rd_reg;
          wb_reg_write_next = ~dmem_we_reg & reg_write_reg;
        end else if (tmo_cnt_reg == CNT_LAST) begin
          // Abort; upstream is released this cycle so the op is not re-issued.
          state_next     = S_IDLE;
          tmo_cnt_next   = '0;
          bus_error_next = 1'b1;
        end else begin
          stall_raw    = 1'b1;
          tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    dmem_req_next = (state_next == S_WAIT);
  end

  // State, request and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      tmo_cnt_reg      <= '0;
      dmem_req_reg     <= 1'b0;
      dmem_we_reg      <= 1'b0;
      dmem_addr_reg    <= '0;
      dmem_be_reg      <= 4'd0;
      dmem_wdata_reg   <= 32'd0;
      funct3_reg       <= 3'd0;
      byte_off_reg     <= 2'd0;
      rd_reg           <= 5'd0;
      reg_write_reg    <= 1'b0;
      wb_valid_reg     <= 1'b0;
      wb_result_reg    <= 32'd0;
      wb_rd_reg        <= 5'd0;
      wb_reg_write_reg <= 1'b0;
      misaligned_reg   <= 1'b0;
      bus_error_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      dmem_req_reg     <= dmem_req_next;
      dmem_we_reg      <= dmem_we_next;
      dmem_addr_reg    <= dmem_addr_next;
      dmem_be_reg      <= dmem_be_next;
      dmem_wdata_reg   <= dmem_wdata_next;
      funct3_reg       <= funct3_next;
      byte_off_reg     <= byte_off_next;
      rd_reg           <= rd_next;
      reg_write_reg    <= reg_write_next;
      wb_valid_reg     <= wb_valid_next;
      wb_result_reg    <= wb_result_next;
      wb_rd_reg        <= wb_rd_next;
      wb_reg_write_reg <= wb_reg_write_next;
      misaligned_reg   <= misaligned_next;
      bus_error_reg    <= bus_error_next;
    end
  end

  // Stall stays low while reset is held so every output reads 0 in reset.
  assign mem_stall        = stall_raw & ~reset;
  assign dmem_req         = dmem_req_reg;
  assign dmem_we          = dmem_we_reg;
  assign dmem_addr        = dmem_addr_reg;
  assign dmem_be          = dmem_be_reg;
  assign dmem_wdata       = dmem_wdata_reg;
  assign mem_wb_valid     = wb_valid_reg;
  assign mem_wb_result    = wb_result_reg;
  assign mem_wb_rd        = wb_rd_reg;
  assign mem_wb_reg_write = wb_reg_write_reg;
  assign misaligned       = misaligned_reg;
  assign bus_error        = bus_error_reg;

endmodule

// File: tb/tb_memory_access.sv
// Bench for the MEM stage: directed scenarios plus randomized ops checked
// against a behavioural model of loads, stores, alignment and timeout.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_rs2_data;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_wb_valid;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        misaligned;
  logic        bus_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  memory_access #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .mem_wb_valid(mem_wb_valid), .mem_wb_result(mem_wb_result),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load value: shift the addressed lane down, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    v  = word >> (8 * int'(addr[1:0]));
    sb = v[7:0];
    sh = v[15:0];
    case (int'(f3))
      0:       r = sb;
      1:       r = sh;
      4:       r = v & 32'h0000_00FF;
      5:       r = v & 32'h0000_FFFF;
      default: r = word;
    endcase
    return r;
  endfunction

  // ready_after: WAIT cycles without ready before ready is given (>=16 never).
  task automatic do_mem(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rword,
                        input int ready_after, input logic [4:0] rd, input logic rw);
    int          nb;
    logic        bad;
    logic        is_store;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_res;
    nb       = 1 << int'(f3[1:0]);
    bad      = (f3[1:0] == 2'b11) || ((int'(addr[1:0]) % nb) != 0);
    is_store = wr_en && !rd_en;
    exp_be   = 4'(((1 << nb) - 1) << int'(addr[1:0]));
    exp_wd   = (nb == 1) ? wd[7:0] * 32'h0101_0101 :
               (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    exp_res  = model_load(f3, addr, rword);

    ex_mem_valid = 1'b1; ex_mem_mem_read = rd_en; ex_mem_mem_write = wr_en;
    ex_mem_funct3 = f3; ex_mem_alu_result = addr; ex_mem_rs2_data = wd;
    ex_mem_rd = rd; ex_mem_reg_write = rw;
    dmem_ready = 1'($urandom_range(0, 1));
    #1;
    total_cnt++; if (mem_stall !== !bad) $display("FAIL %s issue_stall: got %0b want %0b", tag, mem_stall, !bad); else pass_cnt++;
    tick();
    ex_mem_valid = 1'b0; dmem_ready = 1'b0;
    $display("txn %s rd=%0b wr=%0b f3=%0d addr=%h wd=%h rword=%h ready_after=%0d dropped=%0b",
             tag, rd_en, wr_en, f3, addr, wd, rword, ready_after, bad);
    if (bad) begin
      total_cnt++; if (misaligned !== 1'b1) $display("FAIL %s misaligned_pulse: got %0b want 1", tag, misaligned); else pass_cnt++;
      total_cnt++; if (dmem_req !== 1'b0) $display("FAIL %s dropped_req: got %0b want 0", tag, dmem_req); else pass_cnt++;
      total_cnt++; if (mem_wb_valid !== 1'b0) $display("FAIL %s dropped_wb: got %0b want 0", tag, mem_wb_valid); else pass_cnt++;
      total_cnt++; if (mem_stall !== 1'b0) $display("FAIL %s dropped_stall: got %0b want 0", tag, mem_stall); else pass_cnt++;
      tick();
      total_cnt++; if (misaligned !== 1'b0) $display("FAIL %s misaligned_clear: got %0b want 0", tag, misaligned); else pass_cnt++;
    end else begin
      total_cnt++; if (dmem_req !== 1'b1) $display("FAIL %s req: got %0b want 1", tag, dmem_req); else pass_cnt++;
      total_cnt++; if (dmem_we !== is_store) $display("FAIL %s we: got %0b want %0b", tag, dmem_we, is_store); else pass_cnt++;
      total_cnt++; if (dmem_addr !== 12'(addr & 32'hFFC)) $display("FAIL %s addr: got %h want %h", tag, dmem_addr, 12'(addr & 32'hFFC)); else pass_cnt++;
      total_cnt++; if (dmem_be !== exp_be) $display("FAIL %s be: got %b want %b", tag, dmem_be, exp_be); else pass_cnt++;
      if (is_store) begin
        total_cnt++; if (dmem_wdata !== exp_wd) $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, exp_wd); else pass_cnt++;
      end
      for (int w = 0; w < 16; w++) begin
        if (w == ready_after) begin
          dmem_ready = 1'b1; dmem_rdata = rword;
          #1;
          total_cnt++; if (mem_stall !== 1'b0) $display("FAIL %s ready_stall: got %0b want 0", tag, mem_stall); else pass_cnt++;
          tick();
          dmem_ready = 1'b0; dmem_rdata = $urandom;
          total_cnt++; if (mem_wb_valid !== 1'b1) $display("FAIL %s wb_valid: got %0b want 1", tag, mem_wb_valid); else pass_cnt++;
          total_cnt++; if (mem_wb_reg_write !== (rw && !is_store)) $display("FAIL %s wb_reg_write: got %0b want %0b", tag, mem_wb_reg_write, rw && !is_store); else pass_cnt++;
          total_cnt++; if (dmem_req !== 1'b0) $display("FAIL %s req_drop: got %0b want 0", tag, dmem_req); else pass_cnt++;
          if (!is_store) begin
            total_cnt++; if (mem_wb_result !== exp_res) $display("FAIL %s load_result: got %h want %h", tag, mem_wb_result, exp_res); else pass_cnt++;
            total_cnt++; if (mem_wb_rd !== rd) $display("FAIL %s wb_rd: got %0d want %0d", tag, mem_wb_rd, rd); else pass_cnt++;
          end
          break;
        end else if (w == 15) begin
          dmem_ready = 1'b0;
          #1;
          total_cnt++; if (mem_stall !== 1'b0) $display("FAIL %s timeout_stall: got %0b want 0", tag, mem_stall); else pass_cnt++;
          tick();
          total_cnt++; if (bus_error !== 1'b1) $display("FAIL %s bus_error: got %0b want 1", tag, bus_error); else pass_cnt++;
          total_cnt++; if (mem_wb_valid !== 1'b0) $display("FAIL %s timeout_wb: got %0b want 0", tag, mem_wb_valid); else pass_cnt++;
          total_cnt++; if (dmem_req !== 1'b0) $display("FAIL %s timeout_req: got %0b want 0", tag, dmem_req); else pass_cnt++;
          tick();
          total_cnt++; if (bus_error !== 1'b0) $display("FAIL %s bus_error_clear: got %0b want 0", tag, bus_error); else pass_cnt++;
          break;
        end else begin
          dmem_ready = 1'b0; dmem_rdata = $urandom;
          #1;
          total_cnt++; if (mem_stall !== 1'b1) $display("FAIL %s wait_stall: got %0b want 1", tag, mem_stall); else pass_cnt++;
          tick();
          total_cnt++; if (dmem_req !== 1'b1 || dmem_be !== exp_be) $display("FAIL %s wait_hold: got req=%0b be=%b want req=1 be=%b", tag, dmem_req, dmem_be, exp_be); else pass_cnt++;
        end
      end
    end
  endtask

  task automatic do_alu(input string tag, input logic [31:0] res, input logic [4:0] rd, input logic rw);
    ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
    ex_mem_alu_result = res; ex_mem_rs2_data = $urandom; ex_mem_funct3 = 3'($urandom);
    ex_mem_rd = rd; ex_mem_reg_write = rw; dmem_ready = 1'($urandom_range(0, 1));
    #1;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL %s alu_stall: got %0b want 0", tag, mem_stall); else pass_cnt++;
    tick();
    ex_mem_valid = 1'b0; dmem_ready = 1'b0;
    $display("txn %s alu result=%h rd=%0d rw=%0b", tag, res, rd, rw);
    total_cnt++; if (mem_wb_valid !== 1'b1) $display("FAIL %s alu_wb_valid: got %0b want 1", tag, mem_wb_valid); else pass_cnt++;
    total_cnt++; if (mem_wb_result !== res) $display("FAIL %s alu_result: got %h want %h", tag, mem_wb_result, res); else pass_cnt++;
    total_cnt++; if (mem_wb_rd !== rd || mem_wb_reg_write !== rw) $display("FAIL %s alu_rd: got rd=%0d rw=%0b want rd=%0d rw=%0b", tag, mem_wb_rd, mem_wb_reg_write, rd, rw); else pass_cnt++;
    total_cnt++; if (dmem_req !== 1'b0) $display("FAIL %s alu_req: got %0b want 0", tag, dmem_req); else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h10; ex_mem_rs2_data = 32'h0;
    ex_mem_rd = 5'd1; ex_mem_reg_write = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    tick(); tick();
    #1;
    total_cnt++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, mem_stall, mem_wb_valid,
         mem_wb_result, mem_wb_rd, mem_wb_reg_write, misaligned, bus_error} !== '0)
      $display("FAIL reset_outputs: got req=%0b stall=%0b wb_valid=%0b result=%h want all 0",
               dmem_req, mem_stall, mem_wb_valid, mem_wb_result);
    else pass_cnt++;
    ex_mem_valid = 1'b0;
    reset = 1'b0;
    tick();
    $display("txn reset");
  endtask

  task automatic test_directed();
    do_mem("lw_wait3", 1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 32'hDEAD_BEEF, 2, 5'd5, 1'b1);
    do_mem("lb_neg", 1'b1, 1'b0, 3'b000, 32'h013, 32'h0, 32'h8011_2233, 0, 5'd6, 1'b1);
    total_cnt++; if (mem_wb_result !== 32'hFFFF_FF80) $display("FAIL lb_const: got %h want ffffff80", mem_wb_result); else pass_cnt++;
    do_mem("lbu", 1'b1, 1'b0, 3'b100, 32'h013, 32'h0, 32'h8011_2233, 1, 5'd7, 1'b1);
    total_cnt++; if (mem_wb_result !== 32'h0000_0080) $display("FAIL lbu_const: got %h want 00000080", mem_wb_result); else pass_cnt++;
    do_mem("sh", 1'b0, 1'b1, 3'b001, 32'h006, 32'h0000_ABCD, 32'h0, 0, 5'd8, 1'b1);
    do_mem("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h002, 32'h0, 32'h0, 0, 5'd9, 1'b1);
    do_mem("lh_odd", 1'b1, 1'b0, 3'b001, 32'h005, 32'h0, 32'h0, 0, 5'd9, 1'b1);
    do_mem("f3_011", 1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 5'd9, 1'b1);
    do_mem("f3_111", 1'b0, 1'b1, 3'b111, 32'h000, 32'h0, 32'h0, 0, 5'd9, 1'b1);
    do_mem("rw_both", 1'b1, 1'b1, 3'b101, 32'h00A, 32'h1234_5678, 32'hC0DE_F00D, 0, 5'd10, 1'b1);
    do_mem("sb_lane3", 1'b0, 1'b1, 3'b000, 32'h00F, 32'h0000_00A5, 32'h0, 3, 5'd11, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_alu("b2b_add", 32'h0000_1234, 5'd3, 1'b1);
    do_mem("b2b_lw", 1'b1, 1'b0, 3'b010, 32'h020, 32'h0, 32'h1357_9BDF, 1, 5'd4, 1'b1);
    do_alu("b2b_add2", 32'hCAFE_0001, 5'd12, 1'b0);
    do_alu("b2b_add3", 32'h0000_0042, 5'd13, 1'b1);
  endtask

  task automatic test_timeout();
    do_mem("timeout_lw", 1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h0, 100, 5'd14, 1'b1);
    do_mem("late_ready", 1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 32'h600D_D00D, 15, 5'd15, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    ex_mem_valid = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h080; ex_mem_rd = 5'd16; ex_mem_reg_write = 1'b1;
    dmem_ready = 1'b0;
    tick();
    ex_mem_valid = 1'b0;
    tick();
    total_cnt++; if (dmem_req !== 1'b1) $display("FAIL midreset_req_before: got %0b want 1", dmem_req); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL midreset_stall: got %0b want 0", mem_stall); else pass_cnt++;
    tick();
    total_cnt++; if (dmem_req !== 1'b0 || mem_wb_valid !== 1'b0) $display("FAIL midreset_req: got req=%0b wb=%0b want 0 0", dmem_req, mem_wb_valid); else pass_cnt++;
    reset = 1'b0;
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    total_cnt++; if (mem_wb_valid !== 1'b0 || dmem_req !== 1'b0) $display("FAIL midreset_after: got wb=%0b req=%0b want 0 0", mem_wb_valid, dmem_req); else pass_cnt++;
    $display("txn reset_mid_wait");
    do_alu("post_reset_alu", 32'h0BAD_F00D, 5'd17, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int          kind;
      int          ra;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      ra   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
      case (kind)
        0:       do_alu("rnd_alu", $urandom, 5'($urandom), 1'($urandom));
        1:       do_mem("rnd_load", 1'b1, 1'b0, 3'($urandom), addr, $urandom, $urandom, ra, 5'($urandom), 1'($urandom));
        2:       do_mem("rnd_store", 1'b0, 1'b1, 3'($urandom), addr, $urandom, $urandom, ra, 5'($urandom), 1'($urandom));
        default: do_mem("rnd_both", 1'b1, 1'b1, 3'($urandom), addr, $urandom, $urandom, ra, 5'($urandom), 1'($urandom));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
